// File: rtl/uart_block_tx_pkg.sv
// Shared definitions for the 128-bit block UART transmitter.
//   tx_state_e        : byte-engine FSM encoding (IDLE, START, DATA, STOP)
//   DEF_CLOCK_PER_BIT : default clocks per bit (100 MHz / 9600 baud)
//   DEF_CNT_W         : default baud counter width
//   BYTES_PER_BLOCK   : bytes sent per block (16)
package uart_block_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DEF_CLOCK_PER_BIT = 10417;
  localparam int DEF_CNT_W         = 14;
  localparam int BYTES_PER_BLOCK   = 16;
  localparam int BLOCK_W           = 8 * BYTES_PER_BLOCK;

endpackage

// File: rtl/uart_byte_tx.sv
// One 8N1 byte transmitter, LSB first, no parity.
//   clk, rst : system clock, synchronous active-high reset
//   start    : load data and begin a frame (honoured only while ready)
//   data     : byte to send
//   tx       : registered serial line, idles high
//   ready    : engine can take start this cycle -- idle, or in the last
//              cycle of a stop bit so frames can be chained with no gap
module uart_byte_tx
  import uart_block_tx_pkg::*;
#(
  parameter int CLOCK_PER_BIT = DEF_CLOCK_PER_BIT,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  tx_state_e        state, state_n;
  logic [CNT_W-1:0] baud, baud_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       sh, sh_n;
  logic             tx_n;
  logic             baud_end;

  assign baud_end = (baud == CNT_W'(CLOCK_PER_BIT - 1));
  assign ready    = (state == ST_IDLE) || ((state == ST_STOP) && baud_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      sh      <= sh_n;
      tx      <= tx_n;
    end
  end

  // tx_n is the line level for the next cycle, so tx changes exactly on
  // the period boundary the baud counter marks.
  always_comb begin
    state_n   = state;
    baud_n    = baud + 1'b1;
    bit_idx_n = bit_idx;
    sh_n      = sh;
    tx_n      = tx;
    unique case (state)
      ST_IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (start) begin
          state_n = ST_START;
          sh_n    = data;
          tx_n    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_n   = ST_DATA;
          baud_n    = '0;
          bit_idx_n = '0;
          tx_n      = sh[0];
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = sh[bit_idx + 3'd1];
          end
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (start) begin
            state_n = ST_START;
            sh_n    = data;
            tx_n    = 1'b0;
          end else begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_block_tx.sv
// Sends a 128-bit block as 16 back-to-back 8N1 UART bytes, MSB byte first.
//   clk, rst    : system clock, synchronous active-high reset
//   block_data  : block to send, sampled on the accept event
//   block_valid : level; only its rising edge starts a transmission
//   tx          : serial line (idles high)
//   busy        : transmission in progress
//   done        : one-cycle pulse when the last stop bit completes
//   overrun     : one-cycle pulse for a rising edge that could not be taken
module uart_block_tx
  import uart_block_tx_pkg::*;
#(
  parameter int CLOCK_PER_BIT = DEF_CLOCK_PER_BIT,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] block_data,
  input  logic               block_valid,
  output logic               tx,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  logic               valid_q;
  logic               accept, can_accept, last_byte;
  logic               byte_start, byte_ready;
  logic [7:0]         byte_data;
  logic [3:0]         byte_cnt;
  logic [BLOCK_W-1:0] shift_q;

  assign accept     = block_valid & ~valid_q;
  // The done cycle still counts as busy: an edge landing there is an overrun.
  assign can_accept = ~busy & ~done;
  assign last_byte  = (byte_cnt == 4'(BYTES_PER_BLOCK - 1));

  // Byte 0 goes straight from block_data to the engine so tx drops on the
  // cycle after the edge; later bytes are chained in the stop bit's last
  // cycle. While busy the engine is never idle, so ready means end-of-byte.
  assign byte_start = (accept & can_accept) | (busy & byte_ready & ~last_byte);
  assign byte_data  = busy ? shift_q[BLOCK_W-1 -: 8] : block_data[BLOCK_W-1 -: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      byte_cnt <= '0;
      shift_q  <= '0;
    end else begin
      valid_q <= block_valid;
      done    <= 1'b0;
      overrun <= 1'b0;
      if (accept) begin
        if (can_accept) begin
          // byte 0 is already in flight; queue bytes 1..15 at the top
          shift_q  <= {block_data[BLOCK_W-9:0], 8'h00};
          byte_cnt <= '0;
          busy     <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (busy && byte_ready) begin
        if (last_byte) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 4'd1;
          shift_q  <= {shift_q[BLOCK_W-9:0], 8'h00};
        end
      end
    end
  end

  uart_byte_tx #(
    .CLOCK_PER_BIT(CLOCK_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .start(byte_start),
    .data (byte_data),
    .tx   (tx),
    .ready(byte_ready)
  );

endmodule
